// File: rtl/keypad_scanner.sv
// keypad_scanner
// Scans a 4x4 active-low matrix keypad one row at a time, debounces each
// press and decodes it to a hex code (row*4 + column). Every accepted code
// is shifted into the low nibble of an entry word, which feeds the
// seven-segment display and a CPU-readable register.
//
// Optional feature: define KEYPAD_AUTOREPEAT_EN to re-emit the held key
// after REPEAT_DELAY samples and then every REPEAT_RATE samples. Without
// the macro, each press is accepted exactly once.
//
// Ports:
//   clk        system clock
//   rst        synchronous, active-high reset
//   col[3:0]   keypad columns, active-low, asynchronous, pulled up
//   row[3:0]   row drive, active-low, exactly one bit low
//   key_valid  one-cycle pulse per accepted key
//   key_code   code of the last accepted key
//   KeyData    entry word, newest digit in bits [3:0]
//
// States:
//   SCAN    | rotating the low row, waiting for any column to go low
//   CONFIRM | row frozen, counting agreeing samples of the candidate code
//   HELD    | key accepted, waiting for DEBOUNCE released samples
module keypad_scanner #(
    parameter int WIDTH        = 32,
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE     = 8,
    parameter int REPEAT_DELAY = 64,
    parameter int REPEAT_RATE  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       col,
    output logic [3:0]       row,
    output logic             key_valid,
    output logic [3:0]       key_code,
    output logic [WIDTH-1:0] KeyData
);

    if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
        $error("keypad_scanner: WIDTH must be a non-zero multiple of 4");
    end
    if (SCAN_DIV < 4) begin : g_bad_div
        $error("keypad_scanner: SCAN_DIV must be >= 4");
    end
    if (DEBOUNCE < 1) begin : g_bad_debounce
        $error("keypad_scanner: DEBOUNCE must be >= 1");
    end
    if (REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_repeat
        $error("keypad_scanner: REPEAT_DELAY and REPEAT_RATE must be >= 1");
    end

    localparam int DW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE - 1);

    typedef enum logic [1:0] {
        SCAN    = 2'd0,
        CONFIRM = 2'd1,
        HELD    = 2'd2
    } state_t;

    state_t        state;
    logic [3:0]    col_m;
    logic [3:0]    col_s;
    logic [DW-1:0] div;
    logic [1:0]    idx;
    logic [3:0]    cand;
    logic [CW-1:0] cnt;
    logic [CW-1:0] rcnt;
    logic          sample;
    logic          pressed;
    logic [1:0]    c;
    logic [3:0]    code;

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int HW   = $clog2(RMAX + 1);
    logic [HW-1:0] hcnt;
    logic          rep;
    logic [HW-1:0] rep_last;

    // First repeat waits the long delay, later ones use the shorter rate.
    assign rep_last = rep ? HW'(REPEAT_RATE - 1) : HW'(REPEAT_DELAY - 1);
`endif

    function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] data,
                                                   input logic [3:0] nib);
        return (data << 4) | WIDTH'(nib);
    endfunction

    assign row     = ~(4'b0001 << idx);
    assign sample  = (div == DIV_LAST);
    assign pressed = ~&col_s;
    assign code    = {idx, c};

    // Lowest-index low column wins when several are pressed together.
    always_comb begin
        c = 2'd3;
        if (!col_s[0])      c = 2'd0;
        else if (!col_s[1]) c = 2'd1;
        else if (!col_s[2]) c = 2'd2;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= SCAN;
            col_m     <= 4'b1111;
            col_s     <= 4'b1111;
            div       <= '0;
            idx       <= 2'd0;
            cand      <= 4'd0;
            cnt       <= '0;
            rcnt      <= '0;
            key_valid <= 1'b0;
            key_code  <= 4'd0;
            KeyData   <= '0;
`ifdef KEYPAD_AUTOREPEAT_EN
            hcnt      <= '0;
            rep       <= 1'b0;
`endif
        end else begin
            col_m     <= col;
            col_s     <= col_m;
            key_valid <= 1'b0;
            div       <= sample ? '0 : div + 1'b1;

            if (sample) begin
                case (state)
                    SCAN: begin
                        if (!pressed) begin
                            idx <= idx + 1'b1;
                        end else if (DEBOUNCE == 1) begin
                            cand      <= code;
                            key_valid <= 1'b1;
                            key_code  <= code;
                            KeyData   <= shift_in(KeyData, code);
                            state     <= HELD;
                        end else begin
                            cand  <= code;
                            cnt   <= CW'(1);
                            state <= CONFIRM;
                        end
                    end
                    CONFIRM: begin
                        if (pressed && code == cand) begin
                            if (cnt == DEB_LAST) begin
                                key_valid <= 1'b1;
                                key_code  <= cand;
                                KeyData   <= shift_in(KeyData, cand);
                                cnt       <= '0;
                                state     <= HELD;
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end else begin
                            cnt   <= '0;
                            idx   <= idx + 1'b1;
                            state <= SCAN;
                        end
                    end
                    HELD: begin
                        if (pressed) begin
                            rcnt <= '0;
`ifdef KEYPAD_AUTOREPEAT_EN
                            if (hcnt == rep_last) begin
                                key_valid <= 1'b1;
                                KeyData   <= shift_in(KeyData, cand);
                                hcnt      <= '0;
                                rep       <= 1'b1;
                            end else begin
                                hcnt <= hcnt + 1'b1;
                            end
`endif
                        end else begin
`ifdef KEYPAD_AUTOREPEAT_EN
                            hcnt <= '0;
                            rep  <= 1'b0;
`endif
                            if (rcnt == DEB_LAST) begin
                                rcnt  <= '0;
                                idx   <= idx + 1'b1;
                                state <= SCAN;
                            end else begin
                                rcnt <= rcnt + 1'b1;
                            end
                        end
                    end
                    default: state <= SCAN;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner
// Directed bench for keypad_scanner (SCAN_DIV=4, DEBOUNCE=3, WIDTH=32).
// A small keypad model turns a 16-bit "keys held" mask plus the row drive
// into column levels. Stimulus pushes the expected (key_code, KeyData) of
// every accept into a queue; a monitor pops one entry per key_valid pulse.
// Build with KEYPAD_AUTOREPEAT_EN defined to exercise auto-repeat.
module tb_keypad_scanner;

    localparam int WIDTH = 32;

    typedef struct {
        logic [3:0]       code;
        logic [WIDTH-1:0] data;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [3:0]       col;
    logic [3:0]       row;
    logic             key_valid;
    logic [3:0]       key_code;
    logic [WIDTH-1:0] KeyData;
    logic [15:0]      keys = 16'h0000;

    exp_t q[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;

    keypad_scanner #(
        .WIDTH(WIDTH), .SCAN_DIV(4), .DEBOUNCE(3),
        .REPEAT_DELAY(4), .REPEAT_RATE(2)
    ) dut (
        .clk(clk), .rst(rst), .col(col), .row(row),
        .key_valid(key_valid), .key_code(key_code), .KeyData(KeyData)
    );

    always #5 clk = ~clk;

    // Keypad matrix: a held key pulls its column low while its row is driven low.
    always_comb begin
        col = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int k = 0; k < 4; k++)
                if (!row[r] && keys[r*4+k]) col[k] = 1'b0;
    end

    always @(negedge clk) begin
        if (key_valid) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse: key_valid=1 key_code=%h KeyData=%h, required no pulse",
                         key_code, KeyData);
            end else begin
                mon_e = q.pop_front();
                if (key_code !== mon_e.code || KeyData !== mon_e.data) begin
                    errors++;
                    $display("FAIL accept: key_code=%h KeyData=%h, required key_code=%h KeyData=%h",
                             key_code, KeyData, mon_e.code, mon_e.data);
                end
            end
        end
    end

    task automatic push(input logic [3:0] code, input logic [WIDTH-1:0] data);
        exp_t e;
        e.code = code;
        e.data = data;
        q.push_back(e);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic wait_drain(input string name, input int max);
        int n = 0;
        while (q.size() != 0 && n < max) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d expected pulses missing after %0d cycles, required 0", name, q.size(), max);
            q.delete();
        end
    endtask

    task automatic wait_row(input string name, input logic [3:0] target, input logic want_eq, input int max);
        int n = 0;
        while (((row == target) != want_eq) && n < max) begin
            @(negedge clk);
            n++;
        end
        if ((row == target) != want_eq) begin
            checks++;
            errors++;
            $display("FAIL %s: row=%b timed out, required row %s %b", name, row,
                     want_eq ? "==" : "!=", target);
        end
    endtask

    task automatic hold_release(input int hold);
        repeat (hold) @(negedge clk);
        keys = 16'h0000;
        repeat (24) @(negedge clk);
    endtask

    initial begin
        logic [3:0] exp_row;
        int n;

        // Reset
        rst  = 1'b1;
        keys = 16'h0000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_row", row, 4'b1110);
        check("reset_valid", key_valid, 1'b0);
        check("reset_code", key_code, 4'h0);
        check("reset_data", KeyData, 32'h0);
        rst = 1'b0;

        // Idle rotation: each row held 4 cycles, period 16
        for (int k = 0; k < 40; k++) begin
            exp_row = ~(4'b0001 << ((k / 4) % 4));
            check("idle_row", row, exp_row);
            @(negedge clk);
        end

        // Key 9 (row2/col1), then key 3 (row0/col3)
        push(4'h9, 32'h0000_0009);
        keys[9] = 1'b1;
        wait_drain("press9", 200);
        hold_release(8);

        push(4'h3, 32'h0000_0093);
        keys[3] = 1'b1;
        wait_drain("press3", 200);
        hold_release(8);

        // Bounce: key 4 seen at a single row1 sample, then released
        wait_row("bounce_leave", 4'b1101, 1'b0, 40);
        wait_row("bounce_enter", 4'b1101, 1'b1, 40);
        keys[4] = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        keys = 16'h0000;
        wait_row("bounce_exit", 4'b1101, 1'b0, 40);
        check("bounce_next_row", row, 4'b1011);
        repeat (32) @(negedge clk);

        // Two columns low on row1: lowest column wins
        push(4'h4, 32'h0000_0934);
        keys[4] = 1'b1;
        keys[6] = 1'b1;
        wait_drain("multi_col", 200);
        hold_release(8);

`ifdef KEYPAD_AUTOREPEAT_EN
        // Accept, then repeats at +4 samples and +6 samples before release
        push(4'h5, 32'h0000_9345);
        push(4'h5, 32'h0009_3455);
        push(4'h5, 32'h0093_4555);
        keys[5] = 1'b1;
        n = 0;
        while (q.size() == 3 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("repeat_first_seen", q.size(), 2);
        hold_release(26);
        wait_drain("autorepeat", 60);
        push(4'h9, 32'h0934_5559);
`else
        // Long hold: exactly one accept
        push(4'h5, 32'h0000_9345);
        keys[5] = 1'b1;
        wait_drain("long_hold", 200);
        hold_release(100);
        push(4'h9, 32'h0009_3459);
`endif

        // Reset while key 9 is held, then re-accept from a cleared word
        keys[9] = 1'b1;
        wait_drain("press9_again", 200);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("midrst_row", row, 4'b1110);
        check("midrst_valid", key_valid, 1'b0);
        check("midrst_code", key_code, 4'h0);
        check("midrst_data", KeyData, 32'h0);
        push(4'h9, 32'h0000_0009);
        rst = 1'b0;
        wait_drain("reaccept9", 200);
        hold_release(8);

        check("final_code", key_code, 4'h9);
        check("final_data", KeyData, 32'h0000_0009);
        check("final_queue", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
